// File: rtl/dance_pkg.sv
// Shared types and constants for the rhythm game datapath and round sequencer.
package dance_pkg;

  localparam int SCORE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } round_state_t;

  // WON and LOST share the hold-then-return behaviour.
  function automatic logic is_end_state(input round_state_t s);
    return (s == WON) || (s == LOST);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // restart wins over the natural wrap so a new phase always starts from zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Timed game-round sequencer: freezes/clears the score path, times rounds and keeps the high score.
module round_controller #(
  parameter int SCORE_W     = dance_pkg::SCORE_W,
  parameter int WIN_SCORE   = 9,
  parameter int TICK_DIV    = 50_000_000,
  parameter int ROUND_TICKS = 30,
  parameter int HOLD_TICKS  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic               freeze_o,
  output logic               clear_o,
  output logic [1:0]         state_o,
  output logic [5:0]         time_left_o,
  output logic [SCORE_W-1:0] best_o,
  output logic               new_best_o
);

  import dance_pkg::*;

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  round_state_t       state_q, state_d;
  logic               freeze_q, freeze_d;
  logic               clear_q, clear_d;
  logic [5:0]         time_left_q, time_left_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               new_best_q, new_best_d;
  logic               tick;
  logic               restart;
  logic               win;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // The win check ignores the cycle right after start, when the adder tree still shows last round's score.
  always_comb begin
    state_d     = state_q;
    freeze_d    = freeze_q;
    clear_d     = 1'b0;
    time_left_d = time_left_q;
    hold_d      = hold_q;
    best_d      = best_q;
    new_best_d  = new_best_q;
    restart     = 1'b0;
    win         = 1'b0;

    unique case (state_q)
      IDLE: begin
        restart    = 1'b1;
        freeze_d   = 1'b1;
        new_best_d = 1'b0;
        if (start_i) begin
          state_d     = PLAY;
          freeze_d    = 1'b0;
          clear_d     = 1'b1;
          time_left_d = 6'(ROUND_TICKS);
        end
      end
      PLAY: begin
        win = !clear_q && (score_i >= SCORE_W'(WIN_SCORE));
        if (tick) begin
          time_left_d = time_left_q - 1'b1;
        end
        if (win || (tick && time_left_q == 6'd1)) begin
          state_d  = win ? WON : LOST;
          freeze_d = 1'b1;
          restart  = 1'b1;
          hold_d   = HOLD_W'(HOLD_TICKS);
          if (score_i > best_q) begin
            best_d     = score_i;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
        end
      end
      WON, LOST: begin
        if (tick) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HOLD_W'(1)) begin
            state_d    = IDLE;
            new_best_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      freeze_q    <= 1'b1;
      clear_q     <= 1'b0;
      time_left_q <= '0;
      hold_q      <= '0;
      best_q      <= '0;
      new_best_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      freeze_q    <= freeze_d;
      clear_q     <= clear_d;
      time_left_q <= time_left_d;
      hold_q      <= hold_d;
      best_q      <= best_d;
      new_best_q  <= new_best_d;
    end
  end

  assign state_o     = state_q;
  assign freeze_o    = freeze_q;
  assign clear_o     = clear_q;
  assign time_left_o = time_left_q;
  assign best_o      = best_q;
  assign new_best_o  = new_best_q && is_end_state(state_q);

endmodule

// File: tb/tb_round_controller.sv
// Directed and randomized bench for round_controller against a cycle-counting round model.
module tb_round_controller;

  localparam int SCORE_W     = 5;
  localparam int WIN_SCORE   = 9;
  localparam int TICK_DIV    = 4;
  localparam int ROUND_TICKS = 5;
  localparam int HOLD_TICKS  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic               freeze;
  logic               clear;
  logic [1:0]         state;
  logic [5:0]         time_left;
  logic [SCORE_W-1:0] best;
  logic               new_best;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Model: mode 0=idle 1=play 2=won 3=lost; elapsed counts cycles since the phase began.
  int mMode, mTime, mElapsed, mHold, mBest, mFreeze, mClear, mNewBest;

  always #5 clk = ~clk;

  round_controller #(
    .SCORE_W     (SCORE_W),
    .WIN_SCORE   (WIN_SCORE),
    .TICK_DIV    (TICK_DIV),
    .ROUND_TICKS (ROUND_TICKS),
    .HOLD_TICKS  (HOLD_TICKS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .score_i     (score),
    .freeze_o    (freeze),
    .clear_o     (clear),
    .state_o     (state),
    .time_left_o (time_left),
    .best_o      (best),
    .new_best_o  (new_best)
  );

  task automatic modelReset();
    mMode = 0; mTime = 0; mElapsed = 0; mHold = 0;
    mBest = 0; mFreeze = 1; mClear = 0; mNewBest = 0;
  endtask

  task automatic modelEndRound(input int outcome, input int sc);
    mMode = outcome;
    mFreeze = 1;
    mElapsed = 0;
    mHold = HOLD_TICKS;
    if (sc > mBest) begin
      mBest = sc;
      mNewBest = 1;
    end else begin
      mNewBest = 0;
    end
  endtask

  // One clock edge of the round rules, given the inputs present at that edge.
  task automatic modelStep(input bit st, input int sc);
    bit tickNow;
    bit winNow;
    case (mMode)
      0: begin
        mClear = 0;
        if (st) begin
          mMode = 1; mTime = ROUND_TICKS; mElapsed = 0; mClear = 1; mFreeze = 0;
        end
      end
      1: begin
        mElapsed++;
        tickNow = (mElapsed % TICK_DIV) == 0;
        winNow = (mClear == 0) && (sc >= WIN_SCORE);
        mClear = 0;
        if (tickNow) mTime--;
        if (winNow) modelEndRound(2, sc);
        else if (tickNow && mTime == 0) modelEndRound(3, sc);
      end
      default: begin
        mElapsed++;
        if ((mElapsed % TICK_DIV) == 0) begin
          mHold--;
          if (mHold == 0) begin
            mMode = 0; mNewBest = 0; mFreeze = 1; mElapsed = 0;
          end
        end
      end
    endcase
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".state"},     32'(state),     32'(mMode));
    checkValue({tag, ".freeze"},    32'(freeze),    32'(mFreeze));
    checkValue({tag, ".clear"},     32'(clear),     32'(mClear));
    checkValue({tag, ".time_left"}, 32'(time_left), 32'(mTime));
    checkValue({tag, ".best"},      32'(best),      32'(mBest));
    checkValue({tag, ".new_best"},  32'(new_best),  32'(mNewBest));
  endtask

  // Drive inputs for one cycle, advance the model on the edge, check on the falling edge.
  task automatic applyStimulus(input string tag, input bit st, input int sc);
    start = st;
    score = SCORE_W'(sc);
    @(posedge clk);
    modelStep(st, sc);
    @(negedge clk);
    start = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    bit rs;
    int rsc;

    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b0, 0);

    applyStimulus("lost_start", 1'b1, 3);
    checkValue("lost_start.clear_hi", 32'(clear), 32'd1);
    checkValue("lost_start.time_left", 32'(time_left), 32'(ROUND_TICKS));
    for (int i = 1; i <= 20; i++) applyStimulus("lost_play", 1'b0, 3);
    checkValue("lost_end.state", 32'(state), 32'd3);
    checkValue("lost_end.best", 32'(best), 32'd3);
    checkValue("lost_end.new_best", 32'(new_best), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus("lost_hold", 1'b0, 3);
    checkValue("lost_idle.state", 32'(state), 32'd0);

    applyStimulus("win_start", 1'b1, 0);
    for (int i = 1; i <= 5; i++) applyStimulus("win_play", 1'b0, 0);
    applyStimulus("win_hit", 1'b0, 9);
    checkValue("win_hit.state", 32'(state), 32'd2);
    checkValue("win_hit.freeze", 32'(freeze), 32'd1);
    checkValue("win_hit.best", 32'(best), 32'd9);
    checkValue("win_hit.new_best", 32'(new_best), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus("win_hold", (i == 3), 0);
    checkValue("win_idle.state", 32'(state), 32'd0);

    applyStimulus("final_start", 1'b1, 0);
    for (int i = 1; i <= 19; i++) applyStimulus("final_play", (i == 7), 0);
    applyStimulus("final_edge", 1'b0, 9);
    checkValue("final_edge.state", 32'(state), 32'd2);
    for (int i = 0; i < 8; i++) applyStimulus("final_hold", 1'b0, 0);

    applyStimulus("stale_start", 1'b1, 12);
    applyStimulus("stale_mask", 1'b0, 12);
    for (int i = 2; i <= 20; i++) applyStimulus("stale_play", 1'b0, 0);
    checkValue("stale_end.state", 32'(state), 32'd3);
    for (int i = 0; i < 8; i++) applyStimulus("stale_hold", 1'b0, 0);

    applyStimulus("second_start", 1'b1, 5);
    for (int i = 1; i <= 20; i++) applyStimulus("second_play", 1'b0, 5);
    checkValue("second_end.state", 32'(state), 32'd3);
    checkValue("second_end.best", 32'(best), 32'd9);
    checkValue("second_end.new_best", 32'(new_best), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus("second_hold", 1'b0, 5);

    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 7) == 0);
      rsc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8));
      applyStimulus("random", rs, rsc);
    end
    for (int i = 0; i < 30; i++) applyStimulus("drain", 1'b0, 0);

    applyStimulus("areset_start", 1'b1, 1);
    for (int i = 0; i < 3; i++) applyStimulus("areset_play", 1'b0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("areset_now");
    @(posedge clk);
    @(negedge clk);
    checkOutput("areset_held");
    rst_n = 1'b1;
    applyStimulus("after_start", 1'b1, 2);
    for (int i = 1; i <= 20; i++) applyStimulus("after_play", 1'b0, 2);
    checkValue("after_end.best", 32'(best), 32'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/round_controller.md
# round_controller

Game-round sequencer for the rhythm game, sitting directly downstream of the score adder tree. It consumes the summed 5-bit score and runs a timed round. It generates the freeze level that halts the column banks, press detectors and score counters. It also produces a one-cycle clear pulse for the per-column hit checkers and score counters, and tracks a high score for display.

## Interface
Parameters:
- SCORE_W, 5, width of score and best
- WIN_SCORE, 9, score at or above which the round is won
- TICK_DIV, 50_000_000, Clock cycles per round tick (≥2)
- ROUND_TICKS, 30, round length in ticks (1..63)
- HOLD_TICKS, 3, ticks spent in WON/LOST before returning to IDLE (≥1)

Ports:
- Clock  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse from a press detector; begins a round
- score  in  SCORE_W  unsigned total score from adder tree
- freeze  out  1  drives stop of banks, press detectors and score counters
- clear  out  1  one-cycle pulse; resets hit checkers and score counters
- state  out  2  IDLE=0, PLAY=1, WON=2, LOST=3
- time_left  out  6  remaining round ticks
- best  out  SCORE_W  highest end-of-round score since reset
- new_best  out  1  high in WON/LOST when this round raised best

## Operation
- All outputs are registered.
- Reset values: state=IDLE, freeze=1, clear=0, time_left=0, best=0, new_best=0, prescaler=0.
- IDLE:
  - freeze=1.
  - start=1 → PLAY; clear=1; time_left=ROUND_TICKS; prescaler=0.
- PLAY:
  - freeze=0.
  - Prescaler counts 0..TICK_DIV-1. Tick on the cycle it equals TICK_DIV-1, then wrap to 0.
  - On tick: time_left decrements. On a tick with time_left==1: time_left=0 → LOST.
  - score ≥ WIN_SCORE → WON. The check is masked while clear=1, because the stale score from the previous round is still present.
  - Win and final tick on the same edge → WON (win has priority).
  - start is ignored.
- On entering WON or LOST:
  - freeze=1; prescaler=0; hold counter=HOLD_TICKS.
  - If score > best: best=score and new_best=1. Otherwise new_best=0.
  - The score sampled is the value on the transition edge.
- WON/LOST:
  - Hold counter decrements on each tick. On the tick where it equals 1 → IDLE.
  - new_best cleared on leaving.
  - start is ignored.
  - time_left holds its value.
- Score is compared unsigned at full SCORE_W. No saturation is performed here.
- Reset asserted mid-operation forces reset values immediately, including best. Reset release is synchronised by the top level.

## Timing
- start sampled high at edge k:
  - state=PLAY, freeze=0 and clear=1 become valid after edge k.
  - clear=0 after edge k+1.
- First tick occurs TICK_DIV cycles after edge k.
- PLAY lasts ROUND_TICKS×TICK_DIV cycles when not won.
- Win latency: score ≥ WIN_SCORE at edge m (m ≥ k+2) → state=WON after edge m.
- WON/LOST duration: HOLD_TICKS×TICK_DIV cycles, then IDLE.
- start arriving on the same edge as the return to IDLE is ignored (state was not yet IDLE).

## Structure
- Shared package dance_pkg holds:
  - round_state_t enum (IDLE, PLAY, WON, LOST; 2 bits)
  - SCORE_W constant
- Sub-module tick_prescaler:
  - Ports: Clock, Reset, restart, tick; parameter TICK_DIV.
  - Counter width $clog2(TICK_DIV).
  - restart zeroes the count.
- Main FSM, time_left counter, hold counter and best register live in round_controller.

## Test plan
All scenarios use TICK_DIV=4, ROUND_TICKS=5, HOLD_TICKS=2, WIN_SCORE=9.
- Reset low for 2 cycles, then release:
  - state=0, freeze=1, clear=0, time_left=0, best=0, new_best=0.
  - Outputs stay unchanged for 10 cycles with start=0.
- start pulse, score held at 3:
  - clear high exactly 1 cycle; time_left=5.
  - time_left decrements every 4 cycles.
  - state=LOST 20 cycles after start; best=3, new_best=1.
  - IDLE 8 cycles later.
- start, then score=9 on cycle 6:
  - state=WON after that edge; freeze=1; best=9; new_best=1.
- Simultaneity and stale score:
  - score=9 arriving on the edge of the final tick → WON, not LOST.
  - score=12 held across the start edge, then dropping to 0 → no WON.
  - start pulses during PLAY and WON → ignored.
- Second round scoring 5 after best=9:
  - LOST with best=9, new_best=0.
- Reset asserted asynchronously mid-PLAY (between edges):
  - Outputs immediately take reset values, including best=0.
